// File: rtl/rs_stream_pkg.sv
// Shared helpers for pipelined-stream endpoints: counter sizing, pointer wrap
// and the early-full threshold that leaves room for in-flight words.
package rs_stream_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_GRACE = 4;
  localparam int FULL_THRESH   = DEFAULT_DEPTH - DEFAULT_GRACE;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int full_thresh(input int depth, input int grace);
    return depth - grace;
  endfunction

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rs_credit_sink_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read so the
// head word falls through to the read port without an extra cycle.
module rs_credit_sink_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rs_pipeline_credit_sink.sv
// Receive-side FWFT buffer that drops if_full_n early enough to absorb GRACE
// in-flight writes; any write that still finds no room is dropped and flagged.
module rs_pipeline_credit_sink
  import rs_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int GRACE      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        if_din,
  input  logic                         if_write,
  output logic                         if_full_n,
  output logic [DATA_WIDTH-1:0]        if_dout,
  output logic                         if_empty_n,
  input  logic                         if_read,
  output logic [$clog2(DEPTH+1)-1:0]   if_count,
  output logic                         overflow
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(full_thresh(DEPTH, GRACE));

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             full_n_q, full_n_d;
  logic             overflow_q, overflow_d;
  logic             rd_acc, wr_acc;

  always_comb begin
    rd_acc     = if_read && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    wr_acc     = if_write && ((count_q < DEPTH_C) || rd_acc);
    count_d    = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (rd_acc) begin
      rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end
    full_n_d   = count_d < THRESH_C;
    overflow_d = overflow_q || (if_write && !wr_acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_n_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_n_q   <= full_n_d;
      overflow_q <= overflow_d;
    end
  end

  rs_credit_sink_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (if_din),
    .rd_addr (rd_ptr_q),
    .rd_data (if_dout)
  );

  assign if_full_n  = full_n_q;
  assign if_empty_n = (count_q != '0);
  assign if_count   = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rs_pipeline_credit_sink.sv
// Two sink instances (16/4 and 5/2) checked every cycle against a queue-based
// model of the buffer; stimulus and checking run in separate processes.
module tb_rs_pipeline_credit_sink;

  localparam int DW     = 32;
  localparam int GRACE1 = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din [2];
  logic [1:0]    wr;
  logic [1:0]    rd;
  logic [1:0]    full_n_v;
  logic [1:0]    empty_v;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int lane, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d actual=0x%0h required=0x%0h t=%0t", name, lane, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int DEPTH = (gi == 0) ? 16 : 5;
    localparam int GRACE = (gi == 0) ? 4 : GRACE1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [DW-1:0] dout;
    logic          full_n, empty_n, ovf;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mq [$];
    bit            m_ovf   = 1'b0;
    bit            m_fulln = 1'b0;

    rs_pipeline_credit_sink #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .GRACE      (GRACE)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .if_din     (din[gi]),
      .if_write   (wr[gi]),
      .if_full_n  (full_n),
      .if_dout    (dout),
      .if_empty_n (empty_n),
      .if_read    (rd[gi]),
      .if_count   (cnt),
      .overflow   (ovf)
    );

    assign full_n_v[gi] = full_n;
    assign empty_v[gi]  = empty_n;

    // Reference: a plain queue of stored words plus sticky overflow.
    initial forever begin : model
      int n;
      bit do_rd, do_wr;
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_fulln = 1'b0;
      end else begin
        n     = mq.size();
        do_rd = rd[gi] && (n > 0);
        do_wr = wr[gi] && ((n < DEPTH) || do_rd);
        if (do_rd) void'(mq.pop_front());
        if (do_wr) mq.push_back(din[gi]);
        if (wr[gi] && !do_wr) m_ovf = 1'b1;
        m_fulln = (mq.size() < DEPTH - GRACE);
      end
    end

    initial forever begin : monitor
      @(negedge clk);
      chk("count", gi, 64'(cnt), 64'(mq.size()));
      chk("empty_n", gi, 64'(empty_n), 64'(mq.size() != 0));
      chk("full_n", gi, 64'(full_n), 64'(m_fulln));
      chk("overflow", gi, 64'(ovf), 64'(m_ovf));
      if (mq.size() != 0) chk("head", gi, 64'(dout), 64'(mq[0]));
      if (rd[gi] && empty_n)
        $display("lane%0d pop 0x%08h count=%0d", gi, dout, cnt);
    end

    // Outputs must clear as soon as reset rises, without waiting for a clock.
    initial forever begin : reset_watch
      @(posedge reset);
      #1;
      if ($time > 20) begin
        chk("rst_count", gi, 64'(cnt), 64'd0);
        chk("rst_empty_n", gi, 64'(empty_n), 64'd0);
        chk("rst_full_n", gi, 64'(full_n), 64'd0);
        chk("rst_overflow", gi, 64'(ovf), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int sent;
    int cyc;
    bit ok;
    bit fn_hist [$];
    wr     = '0;
    rd     = '0;
    din[0] = '0;
    din[1] = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
    step();

    // Single word: visible after the write edge, gone after the pop edge.
    wr[0] = 1'b1; din[0] = 32'h11; step();
    wr[0] = 1'b0; rd[0] = 1'b1; step();
    rd[0] = 1'b0; step();

    // Fill to 16, then simultaneous pop/push at full, then one dropped write.
    for (int i = 0; i < 16; i++) begin
      wr[0] = 1'b1; din[0] = 32'h100 + i; step();
    end
    rd[0] = 1'b1; din[0] = 32'hAA; step();
    rd[0] = 1'b0; din[0] = 32'hDEAD; step();
    wr[0] = 1'b0; step();
    rd[0] = 1'b1;
    repeat (16) step();
    rd[0] = 1'b0; step();

    // Reset pulse at occupancy 7, then the next word must come out first.
    for (int i = 0; i < 7; i++) begin
      wr[0] = 1'b1; din[0] = 32'h200 + i; step();
    end
    wr[0] = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    wr[0] = 1'b1; din[0] = 32'h77; step();
    wr[0] = 1'b0; step();
    rd[0] = 1'b1; step();
    rd[0] = 1'b0; step();

    // Lane 1: upstream honours if_full_n only after GRACE1+1 edges of delay.
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || empty_v[1]) && cyc < 2000) begin
      fn_hist.push_back(full_n_v[1]);
      ok = (fn_hist.size() > GRACE1) ? fn_hist[fn_hist.size() - 1 - GRACE1] : 1'b0;
      wr[1]  = (sent < 40) && ok && ($urandom_range(0, 3) != 0);
      din[1] = 32'h1000 + sent;
      if (sent < 20) rd[1] = ($urandom_range(0, 3) == 0);
      else           rd[1] = ($urandom_range(0, 2) != 0);
      step();
      if (wr[1]) sent++;
      cyc++;
    end
    wr[1] = 1'b0;
    rd[1] = 1'b0;
    chk("stream_sent", 1, 64'(sent), 64'd40);
    chk("stream_drained", 1, 64'(empty_v[1]), 64'd0);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
